// File: rtl/mips_reg_hazard_scheduler.sv
// Reg-stage hazard scheduler: a three-slot scoreboard of in-flight register
// writes (EX, MEM, WB) that produces the stall request and forwarding selects.
module mips_reg_hazard_scheduler #(
   parameter int unsigned REG_BITS = 5,
   parameter int unsigned CNT_BITS = 16
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                valid,
   input  logic                kill,
   input  logic [REG_BITS-1:0] src1,
   input  logic [REG_BITS-1:0] src2,
   input  logic                src1Used,
   input  logic                src2Used,
   input  logic [REG_BITS-1:0] dest,
   input  logic                destWrite,
   input  logic                isLoad,
   input  logic                isBranch,
   output logic                stall,
   output logic [1:0]          fwd1,
   output logic [1:0]          fwd2,
   output logic [CNT_BITS-1:0] stallCount
);

   // The WB slot never needs its load flag: a WB value is always forwardable.
   logic                ex_live_q, mem_live_q, wb_live_q;
   logic                ex_live_d;
   logic [REG_BITS-1:0] ex_dest_q, mem_dest_q, wb_dest_q;
   logic                ex_load_q, mem_load_q;
   logic [CNT_BITS-1:0] cnt_q, cnt_d;
   logic                hazard1, hazard2;

   // Operand s needs a stall when its producer cannot yet supply the value.
   function automatic logic operand_hazard(
      input logic                s,
      input logic [REG_BITS-1:0] idx,
      input logic                branch,
      input logic                ex_live,
      input logic [REG_BITS-1:0] ex_dest,
      input logic                ex_load,
      input logic                mem_live,
      input logic [REG_BITS-1:0] mem_dest,
      input logic                mem_load
   );
      logic ex_hit, mem_hit;
      ex_hit  = ex_live && (ex_dest == idx);
      mem_hit = mem_live && (mem_dest == idx);
      return s && ((ex_hit && (ex_load || branch)) || (branch && mem_hit && mem_load));
   endfunction

   // Youngest live match wins; non-live slots (including r0 writes) never match.
   function automatic logic [1:0] forward_sel(
      input logic [REG_BITS-1:0] idx,
      input logic                ex_live,
      input logic [REG_BITS-1:0] ex_dest,
      input logic                mem_live,
      input logic [REG_BITS-1:0] mem_dest,
      input logic                wb_live,
      input logic [REG_BITS-1:0] wb_dest
   );
      if (ex_live && ex_dest == idx) return 2'd1;
      if (mem_live && mem_dest == idx) return 2'd2;
      if (wb_live && wb_dest == idx) return 2'd3;
      return 2'd0;
   endfunction

   // Combinational stall and forwarding decisions for the current Reg-stage instruction.
   always_comb begin
      hazard1 = operand_hazard(valid && src1Used && (src1 != '0), src1, isBranch,
                               ex_live_q, ex_dest_q, ex_load_q,
                               mem_live_q, mem_dest_q, mem_load_q);
      hazard2 = operand_hazard(valid && src2Used && (src2 != '0), src2, isBranch,
                               ex_live_q, ex_dest_q, ex_load_q,
                               mem_live_q, mem_dest_q, mem_load_q);
      stall   = !kill && (hazard1 || hazard2);
      fwd1    = forward_sel(src1, ex_live_q, ex_dest_q, mem_live_q, mem_dest_q,
                            wb_live_q, wb_dest_q);
      fwd2    = forward_sel(src2, ex_live_q, ex_dest_q, mem_live_q, mem_dest_q,
                            wb_live_q, wb_dest_q);
   end

   // Next EX entry and saturating stall counter.
   always_comb begin
      ex_live_d = destWrite && (dest != '0) && valid && !stall && !kill;
      cnt_d     = cnt_q;
      if (stall && (cnt_q != '1)) begin
         cnt_d = cnt_q + CNT_BITS'(1);
      end
   end

   // Scoreboard shifts every cycle so older writes always drain.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         ex_live_q  <= 1'b0;
         mem_live_q <= 1'b0;
         wb_live_q  <= 1'b0;
         ex_dest_q  <= '0;
         mem_dest_q <= '0;
         wb_dest_q  <= '0;
         ex_load_q  <= 1'b0;
         mem_load_q <= 1'b0;
         cnt_q      <= '0;
      end else begin
         wb_live_q  <= mem_live_q;
         wb_dest_q  <= mem_dest_q;
         mem_live_q <= ex_live_q;
         mem_dest_q <= ex_dest_q;
         mem_load_q <= ex_load_q;
         ex_live_q  <= ex_live_d;
         ex_dest_q  <= dest;
         ex_load_q  <= isLoad;
         cnt_q      <= cnt_d;
      end
   end

   assign stallCount = cnt_q;

endmodule

// File: tb/tb_mips_reg_hazard_scheduler.sv
// Bench for mips_reg_hazard_scheduler: directed test-plan steps plus random
// traffic checked against an age-based readiness model of the pipeline.
module tb_mips_reg_hazard_scheduler;

   logic       clock = 1'b0;
   logic       reset;
   logic       valid, kill, src1Used, src2Used, destWrite, isLoad, isBranch;
   logic [4:0] src1, src2, dest;
   logic       stall, stall_s;
   logic [1:0] fwd1, fwd2, fwd1_s, fwd2_s;
   logic [15:0] stallCount;
   logic [1:0]  cnt_s;

   always #5 clock = ~clock;

   mips_reg_hazard_scheduler #(.REG_BITS(5), .CNT_BITS(16)) dut (
      .clock(clock), .reset(reset), .valid(valid), .kill(kill),
      .src1(src1), .src2(src2), .src1Used(src1Used), .src2Used(src2Used),
      .dest(dest), .destWrite(destWrite), .isLoad(isLoad), .isBranch(isBranch),
      .stall(stall), .fwd1(fwd1), .fwd2(fwd2), .stallCount(stallCount)
   );

   // Narrow counter copy so saturation is reached quickly.
   mips_reg_hazard_scheduler #(.REG_BITS(5), .CNT_BITS(2)) dut_small (
      .clock(clock), .reset(reset), .valid(valid), .kill(kill),
      .src1(src1), .src2(src2), .src1Used(src1Used), .src2Used(src2Used),
      .dest(dest), .destWrite(destWrite), .isLoad(isLoad), .isBranch(isBranch),
      .stall(stall_s), .fwd1(fwd1_s), .fwd2(fwd2_s), .stallCount(cnt_s)
   );

   typedef struct {bit live; int dest; bit ld;} slot_t;
   slot_t pipe[3];   // index = age: 0 EX, 1 MEM, 2 WB
   int  m_cnt, m_cnt_s;
   bit  m_stall;
   int  m_f1, m_f2;
   int  tests = 0, fails = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
      end
   endtask

   // A producer at age a is usable once a reaches the consumer's need:
   // ALU consumers need +1 age for loads, branches need one more than that.
   function automatic bit src_stalls(int s, bit used);
      int need;
      if (!valid || !used || s == 0) return 1'b0;
      for (int a = 0; a < 3; a++) begin
         if (pipe[a].live && pipe[a].dest == s) begin
            need = (isBranch ? 1 : 0) + (pipe[a].ld ? 1 : 0);
            if (a < need) return 1'b1;
         end
      end
      return 1'b0;
   endfunction

   function automatic int mfwd(int s);
      for (int a = 0; a < 3; a++)
         if (pipe[a].live && pipe[a].dest == s) return a + 1;
      return 0;
   endfunction

   task automatic model_clear();
      for (int a = 0; a < 3; a++) pipe[a] = '{1'b0, 0, 1'b0};
      m_cnt = 0;
      m_cnt_s = 0;
   endtask

   task automatic sample(input string tag);
      @(negedge clock);
      m_stall = !kill && (src_stalls(int'(src1), src1Used) || src_stalls(int'(src2), src2Used));
      m_f1 = mfwd(int'(src1));
      m_f2 = mfwd(int'(src2));
      chk({tag, ".stall"}, 32'(stall), 32'(m_stall));
      chk({tag, ".fwd1"}, 32'(fwd1), 32'(m_f1));
      chk({tag, ".fwd2"}, 32'(fwd2), 32'(m_f2));
      chk({tag, ".cnt"}, 32'(stallCount), 32'(m_cnt));
      chk({tag, ".cnt_small"}, 32'(cnt_s), 32'(m_cnt_s));
   endtask

   task automatic adv();
      @(posedge clock);
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      if (m_stall || kill) pipe[0] = '{1'b0, 0, 1'b0};
      else pipe[0] = '{destWrite && dest != 0 && valid, int'(dest), isLoad};
      if (m_stall) begin
         if (m_cnt < 65535) m_cnt++;
         if (m_cnt_s < 3) m_cnt_s++;
      end
      #1;
   endtask

   task automatic ins(input bit v, input bit k, input int s1, input bit u1, input int s2,
                      input bit u2, input int d, input bit dw, input bit ld, input bit br);
      valid = v; kill = k; src1 = 5'(s1); src1Used = u1; src2 = 5'(s2); src2Used = u2;
      dest = 5'(d); destWrite = dw; isLoad = ld; isBranch = br;
   endtask

   task automatic nop();
      ins(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic do_reset();
      reset = 1'b0;
      #1;
      model_clear();
      chk("rst.stall", 32'(stall), 32'd0);
      chk("rst.cnt", 32'(stallCount), 32'd0);
      chk("rst.cnt_small", 32'(cnt_s), 32'd0);
      @(negedge clock);
      reset = 1'b1;
      @(posedge clock);
      #1;
   endtask

   initial begin
      model_clear();
      nop();
      reset = 1'b1;
      #2;
      do_reset();

      // Reset state, no prior writes
      ins(1, 0, 3, 1, 0, 0, 0, 0, 0, 0);
      sample("idle");
      chk("idle.fwd1_exp", 32'(fwd1), 32'd0);
      adv();

      // Load-use
      ins(1, 0, 0, 0, 0, 0, 5, 1, 1, 0); sample("lw5"); adv();
      ins(1, 0, 5, 1, 0, 0, 6, 1, 0, 0); sample("use5a");
      chk("use5a.stall_exp", 32'(stall), 32'd1);
      adv();
      sample("use5b");
      chk("use5b.fwd1_exp", 32'(fwd1), 32'd2);
      chk("use5b.cnt_exp", 32'(stallCount), 32'd1);
      adv();
      nop(); repeat (3) begin sample("drain"); adv(); end

      // Branch on ALU result, then on load result
      ins(1, 0, 0, 0, 0, 0, 7, 1, 0, 0); sample("add7"); adv();
      ins(1, 0, 1, 0, 7, 1, 0, 0, 0, 1); sample("beqa1");
      chk("beqa1.stall_exp", 32'(stall), 32'd1);
      adv();
      sample("beqa2");
      chk("beqa2.fwd2_exp", 32'(fwd2), 32'd2);
      adv();
      ins(1, 0, 0, 0, 0, 0, 7, 1, 1, 0); sample("lw7"); adv();
      ins(1, 0, 1, 0, 7, 1, 0, 0, 0, 1);
      sample("beql1"); chk("beql1.stall_exp", 32'(stall), 32'd1); adv();
      sample("beql2"); chk("beql2.stall_exp", 32'(stall), 32'd1); adv();
      sample("beql3");
      chk("beql3.fwd2_exp", 32'(fwd2), 32'd3);
      chk("beql3.cnt_exp", 32'(stallCount), 32'd4);
      adv();

      // Youngest match wins; r0 never forwards
      ins(1, 0, 0, 0, 0, 0, 4, 1, 0, 0); repeat (3) begin sample("w4"); adv(); end
      ins(1, 0, 4, 1, 0, 0, 0, 0, 0, 0); sample("r4");
      chk("r4.fwd1_exp", 32'(fwd1), 32'd1);
      adv();
      ins(1, 0, 0, 0, 0, 0, 0, 1, 0, 0); repeat (3) begin sample("w0"); adv(); end
      ins(1, 0, 0, 1, 0, 0, 0, 0, 0, 1); sample("r0");
      chk("r0.fwd1_exp", 32'(fwd1), 32'd0);
      chk("r0.stall_exp", 32'(stall), 32'd0);
      adv();

      // Kill beats a load-use hazard
      ins(1, 0, 0, 0, 0, 0, 9, 1, 1, 0); sample("lw9"); adv();
      ins(1, 1, 9, 1, 0, 0, 10, 1, 0, 0); sample("kill9");
      chk("kill9.stall_exp", 32'(stall), 32'd0);
      adv();
      ins(1, 0, 9, 1, 0, 0, 0, 0, 0, 0); sample("after_kill");
      chk("after_kill.fwd1_exp", 32'(fwd1), 32'd2);
      adv();

      // Narrow counter saturated and holds
      ins(1, 0, 0, 0, 0, 0, 5, 1, 1, 0); sample("lw5s"); adv();
      ins(1, 0, 5, 1, 0, 0, 0, 0, 0, 0); sample("sat"); adv();
      chk("sat.small_hold", 32'(cnt_s), 32'd3);

      // Reset in the middle of a stall
      ins(1, 0, 0, 0, 0, 0, 5, 1, 1, 0); sample("lw5r"); adv();
      ins(1, 0, 5, 1, 0, 0, 0, 0, 0, 0); sample("pre_rst");
      chk("pre_rst.stall_exp", 32'(stall), 32'd1);
      do_reset();
      sample("post_rst");
      chk("post_rst.stall_exp", 32'(stall), 32'd0);
      adv();

      // Random traffic; stalled instructions are usually re-presented
      for (int i = 0; i < 400; i++) begin
         if (!(m_stall && $urandom_range(0, 3) != 0)) begin
            ins($urandom_range(0, 7) != 0, $urandom_range(0, 9) == 0,
                $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 3),
                $urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 3) != 0,
                $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0);
         end
         sample("rand");
         adv();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/mips_reg_hazard_scheduler.md
# mips_reg_hazard_scheduler

Hazard scheduler for the MIPS register (decode) stage. It keeps a 3-slot scoreboard of in-flight register writes (EX, MEM, WB) and decides each cycle whether the Reg-stage instruction must stall. It also drives the per-operand forwarding selects for Reg-stage branch compares and for the EX stage. Its `stall` output is the signal the register stage consumes to replace its control word with a bubble.

## Interface
Parameters:
- `REG_BITS`, 5, width of a register index.
- `CNT_BITS`, 16, width of the saturating stall-cycle counter.

Ports:
- `clock`  in  1  stage clock (the `clock` field of the Data_Control_Control bundle).
- `reset`  in  1  asynchronous, active-low reset (the `reset` field of the same bundle).
- `valid`  in  1  Reg-stage slot holds a real instruction.
- `kill`  in  1  squash the Reg-stage instruction; it enters EX as a bubble without stalling.
- `src1`, `src2`  in  REG_BITS  source register indices.
- `src1Used`, `src2Used`  in  1  the operand is actually read.
- `dest`  in  REG_BITS  destination register index.
- `destWrite`  in  1  the instruction writes `dest`.
- `isLoad`  in  1  the instruction is a memory load.
- `isBranch`  in  1  the instruction compares operands in the Reg stage.
- `stall`  out  1  hold PC and the Pc→Reg latch; insert a bubble into EX.
- `fwd1`, `fwd2`  out  2  operand source: 0 = register file, 1 = EX result, 2 = MEM result, 3 = WB write data.
- `stallCount`  out  CNT_BITS  saturating count of stall cycles since reset.

## Operation
- Scoreboard: three registered slots, EX, MEM and WB, each holding {live, dest, isLoad}.
- A slot is live only when its instruction had `destWrite`=1 and `dest`≠0. Register 0 never hazards and never forwards.
- A source s is active when its `srcNUsed`=1, s≠0, and `valid`=1.
- The stall condition is the OR over active sources of:
  - s matches a live EX slot with isLoad=1 (load-use);
  - `isBranch`=1 and s matches any live EX slot;
  - `isBranch`=1 and s matches a live MEM slot with isLoad=1.
- `kill`=1 forces `stall`=0 regardless of operand matches.
- Forwarding select, computed regardless of stall (meaningful only when `stall`=0): the youngest matching live slot wins, EX before MEM before WB. With no match the select is 0.
- Slot update every cycle:
  - WB takes MEM.
  - MEM takes EX.
  - EX takes the Reg-stage instruction {`destWrite`&&`dest`≠0&&`valid`, `dest`, `isLoad`}.
  - EX is forced to a non-live bubble when `stall`=1 or `kill`=1.
- The scoreboard never freezes; older instructions always drain.
- `stallCount` increments on every cycle with `stall`=1 and saturates at all-ones.

## Timing
- Reset (async, `reset`=0):
  - all slots become non-live and `stallCount` becomes 0;
  - the combinational outputs therefore read `stall`=0 and `fwd1`=`fwd2`=0.
- `stall`, `fwd1` and `fwd2` are combinational from the current inputs and slot contents, with zero latency.
- Slots and the counter update on the rising clock edge.
- Load-use stalls exactly 1 cycle: the load moves to MEM, then forwarding from MEM is selected.
- A branch that uses an ALU result stalls 1 cycle and then forwards from MEM.
- A branch that uses a load result stalls 2 cycles and then forwards from WB.
- The maximum consecutive stall is 2 cycles for any single instruction.
- While stalled, the same instruction is re-presented on the inputs by the upstream latch; the scheduler holds no copy of it.
- Reset mid-stall clears everything; the first cycle after release has `stall`=0 for any input.
- Same-cycle `kill` and a hazard: `kill` wins, and neither a stall nor a count increment occurs.

## Test plan
- After reset, `valid`=1 with `src1`=3 and no prior writes -> `stall`=0, `fwd1`=0, `stallCount`=0.
- Load of r5, then next cycle `add` reading r5 -> `stall`=1 for 1 cycle with `stallCount`=1; on the following cycle `stall`=0 and `fwd1`=2.
- `add` to r7, then `beq` reading r7 as `src2` -> 1 stall cycle, then `fwd2`=2. Load to r7, then `beq` on r7 -> 2 stall cycles, then `fwd2`=3, with `stallCount` incremented by 2.
- Writes to r4 in all three slots (three back-to-back ALU ops), then `src1`=4 -> `fwd1`=1, because the youngest match wins. Writes to r0 in all slots, then `src1`=0 -> `fwd1`=0 and `stall`=0.
- Load to r9, then a consumer of r9 arriving with `kill`=1 -> `stall`=0; the following cycle shows the EX slot non-live, so an instruction reading r9 then gets `fwd`=2.
- Force the counter to 0xFFFE, then keep the stall condition asserted for 3 cycles -> `stallCount` reads 0xFFFF and holds. Assert `reset`=0 mid-stall -> `stall`=0 and the counter is 0 immediately.
